// File: rtl/xadc_drp_sched.sv
// xadc_drp_sched: on each XADC end-of-conversion for a mapped channel, reads the
// conversion result over DRP and stores its 12-bit code in one of four result
// slots. The host read port is independent of the DRP sequencer.
// Optional feature: define XADC_OT_ALARM_EN to enable the over-temperature
// alarm with hysteresis on slot0; without it ot_alarm_out is tied to 0.
module xadc_drp_sched #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [11:0] OT_SET      = 12'hB5F,
  parameter logic [11:0] OT_CLR      = 12'hB0E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  output logic        den_out,
  output logic [6:0]  daddr_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  input  logic [15:0] do_in,
  input  logic        drdy_in,
  input  logic        host_req_in,
  input  logic [1:0]  host_sel_in,
  output logic        host_ack_out,
  output logic [11:0] host_data_out,
  output logic        ot_alarm_out,
  output logic [1:0]  err_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

  state_e      r_state;
  logic        r_den;
  logic [6:0]  r_daddr;
  logic [1:0]  r_slot_idx;
  logic [11:0] r_code;
  logic [7:0]  r_tmo_cnt;
  logic [1:0]  r_err;
  logic [11:0] r_slot [4];
  logic        r_ack;
  logic [11:0] r_hdata;

  logic        w_mapped;
  logic [1:0]  w_slot;
  logic        w_unused_lo;

  // Channel-to-slot map; unmapped channels never start a DRP access.
  always_comb begin
    w_mapped = 1'b1;
    w_slot   = 2'd0;
    unique case (channel_in)
      5'h00:   w_slot = 2'd0;
      5'h01:   w_slot = 2'd1;
      5'h02:   w_slot = 2'd2;
      5'h06:   w_slot = 2'd3;
      default: w_mapped = 1'b0;
    endcase
  end

`ifdef XADC_OT_ALARM_EN
  logic r_ot;
`endif

  // DRP sequencer: IDLE -> ISSUE (den pulse) -> WAIT (drdy or timeout) -> STORE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_den      <= 1'b0;
      r_daddr    <= 7'd0;
      r_slot_idx <= 2'd0;
      r_code     <= 12'd0;
      r_tmo_cnt  <= 8'd0;
      r_err      <= 2'b00;
      for (int i = 0; i < 4; i++) r_slot[i] <= 12'd0;
`ifdef XADC_OT_ALARM_EN
      r_ot       <= 1'b0;
`endif
    end else begin
      r_den <= 1'b0;
      // A conversion arriving while a read is in flight is lost.
      if (eoc_in && w_mapped && (r_state != StIdle)) r_err[1] <= 1'b1;
      case (r_state)
        StIdle: begin
          if (eoc_in && w_mapped) begin
            r_slot_idx <= w_slot;
            r_daddr    <= {2'b00, channel_in};
            r_den      <= 1'b1;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_tmo_cnt <= 8'd0;
          r_state   <= StWait;
        end
        StWait: begin
          if (drdy_in) begin
            r_code  <= do_in[15:4];
            r_state <= StStore;
          end else if (r_tmo_cnt == 8'(TIMEOUT_CYC - 1)) begin
            r_err[0] <= 1'b1;
            r_state  <= StIdle;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        StStore: begin
          r_slot[r_slot_idx] <= r_code;
`ifdef XADC_OT_ALARM_EN
          if (r_slot_idx == 2'd0) begin
            if (r_code >= OT_SET)     r_ot <= 1'b1;
            else if (r_code < OT_CLR) r_ot <= 1'b0;
          end
`endif
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Host read port: one-cycle latency, returns the slot value from the request cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_hdata <= 12'd0;
    end else begin
      r_ack   <= host_req_in;
      r_hdata <= host_req_in ? r_slot[host_sel_in] : 12'd0;
    end
  end

  assign den_out       = r_den;
  assign daddr_out     = r_daddr;
  assign dwe_out       = 1'b0;
  assign di_out        = 16'd0;
  assign host_ack_out  = r_ack;
  assign host_data_out = r_hdata;
  assign err_out       = r_err;

`ifdef XADC_OT_ALARM_EN
  assign ot_alarm_out = r_ot;
  assign w_unused_lo  = ^do_in[3:0];
`else
  assign ot_alarm_out = 1'b0;
  assign w_unused_lo  = ^{do_in[3:0], OT_SET, OT_CLR};
`endif

endmodule

// File: tb/tb_xadc_drp_sched.sv
// tb_xadc_drp_sched: directed stimulus with scoreboard queues for host reads and
// DRP address pulses; a negedge monitor pops and compares.
module tb_xadc_drp_sched;

  localparam int unsigned TMO = 64;

`ifdef XADC_OT_ALARM_EN
  localparam logic [2:0] OT_EXP = 3'b110;  // after B60, B20, B0D
`else
  localparam logic [2:0] OT_EXP = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        eoc_in = 1'b0;
  logic [4:0]  channel_in = 5'd0;
  logic        den_out;
  logic [6:0]  daddr_out;
  logic        dwe_out;
  logic [15:0] di_out;
  logic [15:0] do_in = 16'd0;
  logic        drdy_in = 1'b0;
  logic        host_req_in = 1'b0;
  logic [1:0]  host_sel_in = 2'd0;
  logic        host_ack_out;
  logic [11:0] host_data_out;
  logic        ot_alarm_out;
  logic [1:0]  err_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] q_host  [$];
  logic [6:0]  q_daddr [$];

  xadc_drp_sched #(.TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .eoc_in        (eoc_in),
    .channel_in    (channel_in),
    .den_out       (den_out),
    .daddr_out     (daddr_out),
    .dwe_out       (dwe_out),
    .di_out        (di_out),
    .do_in         (do_in),
    .drdy_in       (drdy_in),
    .host_req_in   (host_req_in),
    .host_sel_in   (host_sel_in),
    .host_ack_out  (host_ack_out),
    .host_data_out (host_data_out),
    .ot_alarm_out  (ot_alarm_out),
    .err_out       (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Conversion with drdy 'dly' cycles after the den cycle; returns in the STORE cycle.
  task automatic conv(input logic [4:0] ch, input logic [15:0] d, input int dly);
    q_daddr.push_back({2'b00, ch});
    eoc_in = 1'b1; channel_in = ch;
    tick();
    eoc_in = 1'b0;
    repeat (dly) tick();
    drdy_in = 1'b1; do_in = d;
    tick();
    drdy_in = 1'b0; do_in = 16'd0;
  endtask

  task automatic hread(input logic [1:0] sel, input logic [11:0] exp);
    q_host.push_back(exp);
    host_req_in = 1'b1; host_sel_in = sel;
    tick();
    host_req_in = 1'b0;
  endtask

  // Monitor: compare every ack and every den pulse against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (host_ack_out) begin
        if (q_host.size() == 0) check("host_ack_unexpected", 16'd1, 16'd0);
        else check("host_data", {4'd0, host_data_out}, {4'd0, q_host.pop_front()});
      end else if (host_data_out != 12'd0) begin
        check("host_data_idle_zero", {4'd0, host_data_out}, 16'd0);
      end
      if (den_out) begin
        if (q_daddr.size() == 0) check("den_unexpected", {9'd0, daddr_out}, 16'hFFFF);
        else check("daddr", {9'd0, daddr_out}, {9'd0, q_daddr.pop_front()});
        check("dwe_di_zero", {dwe_out, di_out[14:0]} | {15'd0, di_out[15]}, 16'd0);
      end
    end
  end

  initial begin
    int n;
    repeat (3) tick();
    check("rst_den",   {15'd0, den_out}, 16'd0);
    check("rst_daddr", {9'd0, daddr_out}, 16'd0);
    check("rst_ack",   {15'd0, host_ack_out}, 16'd0);
    check("rst_hdata", {4'd0, host_data_out}, 16'd0);
    check("rst_ot",    {15'd0, ot_alarm_out}, 16'd0);
    check("rst_err",   {14'd0, err_out}, 16'd0);
    reset = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) hread(2'(s), 12'h000);

    // Temperature conversion, drdy two cycles after den.
    conv(5'h00, 16'h9770, 2);
    tick();
    hread(2'd0, 12'h977);
    check("err_after_conv", {14'd0, err_out}, 16'd0);

    // Unmapped channel: no DRP access, nothing changes.
    eoc_in = 1'b1; channel_in = 5'h03;
    tick();
    eoc_in = 1'b0;
    repeat (4) tick();
    check("err_unmapped", {14'd0, err_out}, 16'd0);
    hread(2'd0, 12'h977);
    hread(2'd1, 12'h000);

    // Timeout on VCCINT: WAIT lasts TMO cycles, err visible the cycle after.
    q_daddr.push_back(7'h01);
    eoc_in = 1'b1; channel_in = 5'h01;
    tick();
    eoc_in = 1'b0;
    n = 0;
    while (err_out[0] == 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("tmo_latency", 16'(n), 16'(TMO + 1));
    check("err_tmo", {14'd0, err_out}, 16'h0001);
    hread(2'd1, 12'h000);
    conv(5'h02, 16'hABC5, 1);
    tick();
    hread(2'd2, 12'hABC);
    check("err_after_tmo_recover", {14'd0, err_out}, 16'h0001);

    // Overrun: second eoc during WAIT is dropped, first result stored.
    q_daddr.push_back(7'h00);
    eoc_in = 1'b1; channel_in = 5'h00;
    tick();
    eoc_in = 1'b0;
    tick();
    eoc_in = 1'b1; channel_in = 5'h01;
    tick();
    eoc_in = 1'b0;
    drdy_in = 1'b1; do_in = 16'h9003;
    tick();
    drdy_in = 1'b0; do_in = 16'd0;
    tick();
    check("err_overrun", {14'd0, err_out}, 16'h0003);
    hread(2'd0, 12'h900);
    hread(2'd1, 12'h000);

    // Read slot0 in the very cycle STORE overwrites it.
    conv(5'h00, 16'h9770, 2);
    hread(2'd0, 12'h900);
    hread(2'd0, 12'h977);

    // Over-temperature hysteresis sequence.
    conv(5'h00, 16'hB600, 1);
    tick();
    check("ot_b60", {15'd0, ot_alarm_out}, {15'd0, OT_EXP[2]});
    conv(5'h00, 16'hB200, 1);
    tick();
    check("ot_b20", {15'd0, ot_alarm_out}, {15'd0, OT_EXP[1]});
    conv(5'h00, 16'hB0D0, 1);
    tick();
    check("ot_b0d", {15'd0, ot_alarm_out}, {15'd0, OT_EXP[0]});

    // Reset while in WAIT, then a stray drdy.
    q_daddr.push_back(7'h01);
    eoc_in = 1'b1; channel_in = 5'h01;
    tick();
    eoc_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drdy_in = 1'b1; do_in = 16'hFFF0;
    tick();
    drdy_in = 1'b0; do_in = 16'd0;
    repeat (3) tick();
    check("err_after_reset", {14'd0, err_out}, 16'd0);
    check("ot_after_reset", {15'd0, ot_alarm_out}, 16'd0);
    for (int s = 0; s < 4; s++) hread(2'(s), 12'h000);

    repeat (4) tick();
    check("host_queue_drained", 16'(q_host.size()), 16'd0);
    check("daddr_queue_drained", 16'(q_daddr.size()), 16'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sched.md
XADC_DRP_SCHED -- requirements
Module: xadc_drp_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, SHALL set the DRP drdy wait limit in clk cycles (range 2..255).
REQ-002 Parameter OT_SET, default 12'hB5F (about 85 C), SHALL set the over-temperature assert threshold in 12-bit ADC code.
REQ-003 Parameter OT_CLR, default 12'hB0E (about 75 C), SHALL set the over-temperature release threshold; OT_CLR < OT_SET.
REQ-004 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 eoc_in  input  1  SHALL be the XADC end-of-conversion pulse.
REQ-007 channel_in  input  5  SHALL be the XADC channel number, valid with eoc_in.
REQ-008 den_out  output  1  SHALL be the DRP enable.
REQ-009 daddr_out  output  7  SHALL be the DRP address.
REQ-010 dwe_out  output  1  SHALL be the DRP write enable, constant 0.
REQ-011 di_out  output  16  SHALL be the DRP write data, constant 0.
REQ-012 do_in  input  16  SHALL be the DRP read data.
REQ-013 drdy_in  input  1  SHALL be the DRP data ready.
REQ-014 host_req_in  input  1  SHALL be a one-cycle host read request.
REQ-015 host_sel_in  input  2  SHALL select the result slot, valid with host_req_in.
REQ-016 host_ack_out  output  1  SHALL be the one-cycle read acknowledge.
REQ-017 host_data_out  output  12  SHALL be the read slot value, valid with host_ack_out.
REQ-018 ot_alarm_out  output  1  SHALL be the over-temperature flag.
REQ-019 err_out  output  2  SHALL hold sticky flags: bit0 = DRP timeout, bit1 = EOC overrun.

Function
REQ-020 Slot map SHALL be: slot0 = channel 0x00 (temp), slot1 = 0x01 (VCCINT), slot2 = 0x02 (VCCAUX), slot3 = 0x06 (VCCBRAM); other channels SHALL be ignored with no DRP access.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, STORE.
REQ-022 IDLE -> ISSUE SHALL occur on eoc_in=1 with a mapped channel_in; channel and slot are latched in the same cycle.
REQ-023 ISSUE SHALL drive den_out=1 for exactly one cycle with daddr_out={2'b00,latched channel}, then enter WAIT.
REQ-024 In WAIT, drdy_in=1 SHALL capture do_in[15:4] and enter STORE.
REQ-025 STORE SHALL write the captured code to the slot and return to IDLE; eoc-to-slot-update latency is 3 cycles plus drdy delay.
REQ-026 If drdy_in has not arrived TIMEOUT_CYC cycles after ISSUE, the FSM SHALL set err_out[0], leave the slot unchanged and return to IDLE.
REQ-027 A mapped eoc_in outside IDLE SHALL be dropped and SHALL set err_out[1].
REQ-028 drdy_in outside WAIT SHALL be ignored.
REQ-029 daddr_out SHALL hold its last value and den_out SHALL be 0 outside ISSUE.
REQ-030 host_req_in SHALL be answered with host_ack_out=1 exactly one cycle later; it is independent of the FSM and never stalls.
REQ-031 host_data_out SHALL return the slot value as it stood in the request cycle, also when STORE writes that slot in the same cycle.
REQ-032 host_data_out SHALL be 0 when host_ack_out=0.
REQ-033 Back-to-back requests SHALL each be acknowledged in consecutive cycles.
REQ-034 err_out bits SHALL clear only on reset.

Reset
REQ-035 Reset SHALL force: FSM=IDLE, all slots=0, den_out=0, daddr_out=0, host_ack_out=0, host_data_out=0, ot_alarm_out=0, err_out=0, timeout counter=0.
REQ-036 Reset asserted mid-transaction SHALL abandon it with no slot write, and a later drdy_in SHALL be ignored.

Configuration
REQ-037 Macro XADC_OT_ALARM_EN defined: ot_alarm_out SHALL set on a slot0 write with code >= OT_SET, clear on a slot0 write with code < OT_CLR, and otherwise hold, giving hysteresis.
REQ-038 Macro XADC_OT_ALARM_EN undefined: the comparator logic SHALL be absent and ot_alarm_out SHALL be tied to 0.

Verification
REQ-039 eoc_in with channel 0x00, drdy 2 cycles after den, do_in=16'h9770 -> single den pulse with daddr 7'h00; host read of slot0 returns 12'h977, ack one cycle after req.
REQ-040 eoc_in with channel 0x03 -> no den pulse, slots and err_out unchanged.
REQ-041 Channel 0x01 with drdy never asserted, TIMEOUT_CYC=64 -> err_out=2'b01 after 64 cycles; FSM back in IDLE; next eoc on 0x02 completes normally.
REQ-042 Second eoc_in during WAIT -> err_out[1]=1, no second den pulse; first result stored.
REQ-043 With XADC_OT_ALARM_EN, slot0 codes B60, B20, B0D in sequence -> ot_alarm_out 1, 1, 0; without the macro -> always 0.
REQ-044 Host read of slot0 in the STORE cycle writing 12'h977 over old 12'h900 -> data 12'h900; next read returns 12'h977; reset in WAIT followed by drdy -> all slots 0.
